// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, coordinate width and sync bundle type.
// Imported by vga_sync_gen and vga_delay_line.
package vga_timing_pkg;

   localparam int COORD_W   = 10;
   localparam int MAX_TOTAL = 1 << COORD_W;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT
                              + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT
                              + DEF_V_SYNC + DEF_V_BACK;

   localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
   localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
   localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
   localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

   // Bit order fixes the layout of the 3-bit delay line word.
   typedef struct packed {
      logic hs;
      logic vs;
      logic blank_n;
   } sync_t;

   // Half-open interval test [lo, hi).
   function automatic logic in_window(input logic [COORD_W-1:0] cnt,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
      return (cnt >= lo) && (cnt < hi);
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parameterised-depth shift register for the sync/blank bundle.
// Ports: clk, rst (async, active-high, loads RST_VAL), d in, q out after DEPTH clocks.
module vga_delay_line
   import vga_timing_pkg::*;
#(
   parameter int               DEPTH   = 1,
   parameter int               WIDTH   = $bits(sync_t),
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stg [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stg[i] <= RST_VAL;
      end else begin
         stg[0] <= d;
         for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
   end

   assign q = stg[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running h/v counters, pixel coordinates, delayed sync/blank.
// Ports: vga_clk, RST (async high); xPos, yPos, hsync, vsync, blank_n, frame_end.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter bit SYNC_POL  = 1'b0,
   parameter int PIPE_DLY  = 1
) (
   input  logic               vga_clk,
   input  logic               RST,
   output logic [COORD_W-1:0] xPos,
   output logic [COORD_W-1:0] yPos,
   output logic               hsync,
   output logic               vsync,
   output logic               blank_n,
   output logic               frame_end
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_PRE  = COORD_W'(H_TOTAL - 2);
   localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_VISIBLE);
   localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_VISIBLE);
   localparam logic [COORD_W-1:0] HS_LO  = COORD_W'(HS_START);
   localparam logic [COORD_W-1:0] HS_HI  = COORD_W'(HS_END);
   localparam logic [COORD_W-1:0] VS_LO  = COORD_W'(VS_START);
   localparam logic [COORD_W-1:0] VS_HI  = COORD_W'(VS_END);

   generate
      if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_chk
         $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed counter range");
      end
      if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_dly_chk
         $error("vga_sync_gen: PIPE_DLY must be 1..4");
      end
   endgenerate

   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   logic               h_last;
   logic               v_last;
   logic               h_vis;
   logic               v_vis;
   sync_t              raw;
   sync_t              dly;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);
   assign h_vis  = (h_cnt < H_VIS);
   assign v_vis  = (v_cnt < V_VIS);

   // frame_end is decoded one count early so the flop is high exactly
   // while the counters sit on the last pixel of the frame.
   always_ff @(posedge vga_clk or posedge RST) begin
      if (RST) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         frame_end <= 1'b0;
      end else begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
         frame_end <= (h_cnt == H_PRE) && v_last;
      end
   end

   assign xPos = h_vis ? h_cnt : '0;
   assign yPos = v_vis ? v_cnt : '0;

   always_comb begin
      raw.hs      = in_window(h_cnt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      raw.vs      = in_window(v_cnt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      raw.blank_n = h_vis && v_vis;
   end

   vga_delay_line #(
      .DEPTH   (PIPE_DLY),
      .WIDTH   ($bits(sync_t)),
      .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
   ) u_dly (
      .clk (vga_clk),
      .rst (RST),
      .d   (raw),
      .q   (dly)
   );

   assign hsync   = dly.hs;
   assign vsync   = dly.vs;
   assign blank_n = dly.blank_n;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Upstream timing stage of the DE0 VGA controller. Free-running horizontal and vertical counters generate 640x480@60Hz timing (25 MHz vga_clk). Outputs the xPos/yPos pixel coordinates consumed by the pattern generator, plus hsync, vsync and blank_n to the DAC pins. Sync and blank are delayed through a short pipeline so they stay aligned with the pattern stage's registered colour output.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
PIPE_DLY, 1, clocks of delay on hsync/vsync/blank_n; legal range 1..4

Ports:
vga_clk  in  1  pixel clock, 25 MHz
RST  in  1  asynchronous, active-high reset
xPos  out  10  current column; h_cnt when visible, else 0
yPos  out  10  current row; v_cnt when visible, else 0
hsync  out  1  horizontal sync, delayed PIPE_DLY
vsync  out  1  vertical sync, delayed PIPE_DLY
blank_n  out  1  1 = visible pixel, delayed PIPE_DLY
frame_end  out  1  one-clock pulse on last clock of frame

Behaviour:
- Interface: one clock, vga_clk. RST is asynchronous and active-high.
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- h_cnt runs 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments only on the h_cnt wrap. It runs 0..V_TOTAL-1 and wraps to 0 when h_cnt and v_cnt wrap together.
- Region order within each line and frame: visible, front porch, sync, back porch.
- Horizontal sync active for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656,752).
- Vertical sync active for v_cnt in [490,492), for whole lines.
- Visible region: h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- xPos/yPos are driven directly from the counter registers, with zero latency relative to the count. They are forced to 0 outside the visible region on the respective axis.
- Raw hsync, vsync and blank are decoded from the counters and registered once. That register is stage 1 of a PIPE_DLY-deep delay line.
  - The output at clock t+PIPE_DLY reflects the counters at clock t.
  - PIPE_DLY=1 matches the one-register latency of the pattern stage.
- frame_end:
  - High during exactly the clock in which the counters hold (H_TOTAL-1, V_TOTAL-1).
  - Produced as a registered decode of the preceding count, so it is glitch-free.
  - Not delayed by PIPE_DLY.
- Reset, asynchronous and effective immediately:
  - h_cnt=0, v_cnt=0, so xPos=0 and yPos=0.
  - Every delay-line stage is flushed to inactive: hsync=vsync=~SYNC_POL, blank_n=0.
  - frame_end=0.
- After RST deasserts, counting resumes from (0,0) on the first clock edge. The delay line fills with valid data after PIPE_DLY edges. There is no partial-frame recovery.
- Reset mid-frame: all outputs take their reset values without waiting for a clock edge. The next frame starts at (0,0). The old frame is truncated and vsync is never left stuck active.
- No other inputs exist, so simultaneous events reduce to the h-wrap and v-wrap on the same clock. That case is handled as above.
- Counter width is 10 bits, which is sufficient for H_TOTAL ≤ 1024. A compile-time check flags H_TOTAL or V_TOTAL > 1024.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 default constants;
  - derived H_TOTAL/V_TOTAL and the sync start/end constants;
  - the coordinate width (10).
- One sub-module, vga_delay_line. It is a parameterised-depth shift register, width 3 (hsync, vsync, blank_n), with an async active-high reset loading a per-bit reset value.

Test Plan:
- Reset hold/release, PIPE_DLY=1 -> during RST: xPos=0, yPos=0, hsync=1, vsync=1, blank_n=0, frame_end=0. Outputs settle to their reset values asynchronously, before any clock edge. blank_n rises at the 1st edge after release, and hsync/vsync stay 1.
- Line timing -> hsync low for exactly 96 clocks, period 800. Its falling edge occurs 1 clock after h_cnt reaches 656.
- Frame timing -> vsync low for 1600 clocks (2 lines), period 420000 clocks. frame_end pulses once per 420000 clocks, with (xPos,yPos)=(0,0) on the following clock.
- Visible window -> xPos steps 0..639 and blank_n is high for 640 clocks on lines 0..479. blank_n is 0 for all of lines 480..524, where yPos=0.
- Reset mid-frame at h_cnt=300, v_cnt=200 -> outputs go to reset values without a clock edge. After release, xPos/yPos restart at (0,0) and the next frame_end occurs 420000 clocks after release.
- PIPE_DLY=3 -> hsync/blank_n edges lag the corresponding counter values by exactly 3 clocks. The first valid blank_n appears 3 edges after reset release.
